// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I core constants and the register-dump state type.
//   REG_ADDR_W : register file address width (x0..x31)
//   XLEN       : register width
//   regdump_state_e : state encoding used by regfile_dump. CSUM is only
//                     reachable when REGDUMP_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    CSUM
  } regdump_state_e;

endpackage

// File: rtl/regdump_outreg.sv
// ---------------------------------------------------------------------------
// regdump_outreg
// Single-entry valid/ready output register. A stream source asserts i_load
// only when o_can_load is high; the entry is then overwritten with i_payload
// and becomes valid. An accepted entry with no replacement empties the
// register and clears its payload, so stale sideband bits (such as a "last"
// flag) never linger on the bus.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_load          : write i_payload into the register this cycle
//   i_payload [W]   : data to load
//   i_ready         : consumer accepts the current entry
//   o_valid         : register holds a beat
//   o_payload [W]   : registered beat contents
//   o_can_load      : register is empty or being drained this cycle
// ---------------------------------------------------------------------------
module regdump_outreg #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_payload,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_payload,
  output logic         o_can_load
);

  logic         valid_q, valid_d;
  logic [W-1:0] payload_q, payload_d;

  // A new beat may replace the current one in the same cycle it is accepted,
  // which is what allows back-to-back beats with ready held high.
  assign o_can_load = !valid_q || i_ready;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (i_load) begin
      valid_d   = 1'b1;
      payload_d = i_payload;
    end else if (valid_q && i_ready) begin
      valid_d   = 1'b0;
      payload_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_payload = payload_q;

endmodule

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
// Debug read-out engine for the RV32I register file. A start pulse in IDLE
// walks a spare combinational regfile read port from FIRST_REG to LAST_REG
// and streams each value out over a valid/ready interface that may be
// backpressured. Each beat captures the regfile value in the cycle it is
// loaded into the output register.
// Optional feature (macro REGDUMP_CHECKSUM_EN): a running XOR of the dumped
// words is sent as one extra beat (idx 0, last 1) after the final register.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_start                 : start request, only honoured in IDLE
//   o_busy                  : engine is not idle
//   o_done                  : one-cycle pulse after the final beat is taken
//   o_rs_addr [ADDR_W]      : registered regfile read address
//   i_rs_data [DATA_W]      : regfile data for o_rs_addr, same cycle
//   o_dump_valid/i_dump_ready : output handshake
//   o_dump_data [DATA_W]    : beat payload
//   o_dump_idx  [ADDR_W]    : register index of the beat
//   o_dump_last             : final beat of the dump
// ---------------------------------------------------------------------------
module regfile_dump
  import riscv_pkg::*;
#(
  parameter int DATA_W    = XLEN,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rs_addr,
  input  logic [DATA_W-1:0] i_rs_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [DATA_W-1:0] o_dump_data,
  output logic [ADDR_W-1:0] o_dump_idx,
  output logic              o_dump_last
);

  localparam int PW = DATA_W + ADDR_W + 1;

  regdump_state_e    state_q, state_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic              done_q, done_d;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic              load;
  logic              beat_last;
  logic              can_load;
  logic [PW-1:0]     load_payload;
  logic [PW-1:0]     out_payload;
  logic              at_last;

  assign at_last = (rs_addr_q == ADDR_W'(LAST_REG));

  // Next-state logic. The scan advances only when the output register can
  // take a beat, so o_rs_addr freezes under backpressure and the read port
  // always points at the register that will be captured next.
  always_comb begin
    state_d      = state_q;
    rs_addr_d    = rs_addr_q;
    done_d       = 1'b0;
    load         = 1'b0;
    beat_last    = 1'b0;
    load_payload = '0;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = SCAN;
          rs_addr_d = ADDR_W'(FIRST_REG);
`ifdef REGDUMP_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      SCAN: begin
        if (can_load) begin
          load = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          beat_last = 1'b0;
          csum_d    = csum_q ^ i_rs_data;
`else
          beat_last = at_last;
`endif
          load_payload = {i_rs_data, rs_addr_q, beat_last};
          if (at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DRAIN;
`endif
          end else begin
            rs_addr_d = rs_addr_q + ADDR_W'(1);
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        // The checksum already includes the final register, folded in when
        // that beat was loaded.
        if (can_load) begin
          load         = 1'b1;
          load_payload = {csum_q, {ADDR_W{1'b0}}, 1'b1};
          state_d      = DRAIN;
        end
      end
`endif
      DRAIN: begin
        if (o_dump_valid && i_dump_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset aborts a dump outright; any beat in flight is
  // discarded by the output register's own reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      rs_addr_q <= '0;
      done_q    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rs_addr_q <= rs_addr_d;
      done_q    <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  regdump_outreg #(
    .W(PW)
  ) u_outreg (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (load),
    .i_payload  (load_payload),
    .i_ready    (i_dump_ready),
    .o_valid    (o_dump_valid),
    .o_payload  (out_payload),
    .o_can_load (can_load)
  );

  assign {o_dump_data, o_dump_idx, o_dump_last} = out_payload;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign o_rs_addr = rs_addr_q;

endmodule

// File: tb/tb_regfile_dump.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump
// Randomised scoreboard bench for regfile_dump. Each dump request pushes the
// expected beat sequence (computed from a regfile array) into a queue; a
// monitor on the falling clock edge pops and compares every accepted beat,
// checks that a stalled beat holds steady, and checks the o_done pulse.
// ---------------------------------------------------------------------------
module tb_regfile_dump;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int FIRST_REG = 0;
  localparam int LAST_REG  = 31;
  localparam int NREG      = LAST_REG - FIRST_REG + 1;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int NBEATS    = NREG + 1;
`else
  localparam int NBEATS    = NREG;
`endif
  // Start edge, then one edge per beat, then the edge that raises o_done.
  localparam int DONE_LATENCY = NBEATS + 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } beat_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rs_addr;
  logic [DATA_W-1:0] rs_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_idx;
  logic              dump_last;

  logic [DATA_W-1:0] regs [0:31];
  beat_t             exp_q [$];

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  int beats_seen = 0;
  int done_count = 0;
  int done_cycle = 0;
  int first_valid_cycle = -1;
  int start_cycle = 0;

  regfile_dump #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .FIRST_REG(FIRST_REG),
    .LAST_REG (LAST_REG)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_rs_addr   (rs_addr),
    .i_rs_data   (rs_data),
    .o_dump_valid(dump_valid),
    .i_dump_ready(dump_ready),
    .o_dump_data (dump_data),
    .o_dump_idx  (dump_idx),
    .o_dump_last (dump_last)
  );

  // Combinational regfile read port.
  assign rs_data = regs[rs_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                  name, actual, expected, cycle);
  endtask

  // Monitor: compares accepted beats against the scoreboard, checks that a
  // refused beat is presented unchanged next cycle, and that o_done pulses
  // exactly one cycle after the final beat is taken.
  initial begin
    beat_t e;
    logic  held_valid;
    beat_t held;
    logic  pending_done;
    logic  prev_valid;
    held_valid   = 1'b0;
    held         = '0;
    pending_done = 1'b0;
    prev_valid   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_valid   = 1'b0;
        pending_done = 1'b0;
        prev_valid   = 1'b0;
      end else begin
        if (pending_done || done)
          checkOutput("done_pulse", 64'(done), 64'(pending_done));
        pending_done = 1'b0;
        if (done) begin
          done_count++;
          done_cycle = cycle;
        end
        if (held_valid)
          checkOutput("hold_stable", {31'd0, dump_valid, dump_data, dump_idx, dump_last},
                      {31'd0, 1'b1, held});
        if (dump_valid && !prev_valid && first_valid_cycle < 0)
          first_valid_cycle = cycle;
        if (dump_valid && dump_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL extra_beat: got idx %0d data %0h, expected no beat",
                     dump_idx, dump_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat_data", 64'(dump_data), 64'(e.data));
            checkOutput("beat_idx", 64'(dump_idx), 64'(e.idx));
            checkOutput("beat_last", 64'(dump_last), 64'(e.last));
            beats_seen++;
            if (e.last) pending_done = 1'b1;
          end
        end
        held_valid = dump_valid && !dump_ready;
        held       = {dump_data, dump_idx, dump_last};
        prev_valid = dump_valid;
      end
    end
  end

  function automatic logic readyFor(input int mode, input int k);
    logic [3:0] pat;
    pat = 4'b1001;
    case (mode)
      1:       return pat[3 - (k % 4)];
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  // Issues one dump: fills the scoreboard from the reference regfile, pulses
  // start, then drives ready per mode until o_done or the cycle budget runs
  // out. restart_at pulses start mid-dump; abort_at resets after that many
  // accepted beats.
  task automatic applyStimulus(input int mode, input int restart_at, input int abort_at);
    beat_t             b;
    logic [DATA_W-1:0] csum;
    int                done_before;
    logic              finished;
    csum = '0;
    for (int i = FIRST_REG; i <= LAST_REG; i++) begin
      csum   = csum ^ regs[i];
      b.data = regs[i];
      b.idx  = ADDR_W'(i);
`ifdef REGDUMP_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (i == LAST_REG);
`endif
      exp_q.push_back(b);
    end
`ifdef REGDUMP_CHECKSUM_EN
    b.data = csum;
    b.idx  = '0;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
    done_before       = done_count;
    beats_seen        = 0;
    first_valid_cycle = -1;
    finished          = 1'b0;
    @(posedge clk);
    #1;
    start       = 1'b1;
    dump_ready  = readyFor(mode, 0);
    start_cycle = cycle;
    for (int k = 1; k < 2000 && !finished; k++) begin
      @(posedge clk);
      #1;
      start      = (k == restart_at);
      dump_ready = readyFor(mode, k);
      if (abort_at >= 0 && beats_seen == abort_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_valid", 64'(dump_valid), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_rs_addr", 64'(rs_addr), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        return;
      end
      if (done_count != done_before) finished = 1'b1;
    end
    start = 1'b0;
    if (!finished) begin
      checks++;
      $display("[TB] FAIL dump_timeout: got no o_done, expected o_done within budget");
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("done_count", 64'(done_count - done_before), 64'd1);
    checkOutput("idle_after_done", 64'(busy), 64'd0);
    if (mode == 0) begin
      checkOutput("first_valid_latency", 64'(first_valid_cycle - start_cycle), 64'd2);
      checkOutput("done_latency", 64'(done_cycle - start_cycle), 64'(DONE_LATENCY));
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    dump_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    $display("[TB] reset check");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_valid", 64'(dump_valid), 64'd0);
    checkOutput("reset_last", 64'(dump_last), 64'd0);
    checkOutput("reset_rs_addr", 64'(rs_addr), 64'd0);
    checkOutput("reset_data", 64'(dump_data), 64'd0);
    checkOutput("reset_idx", 64'(dump_idx), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] full scan, ready high");
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    regs[5]  = 32'hDEADBEEF;
    regs[10] = 32'h12345678;
    regs[31] = 32'hCAFEBABE;
    applyStimulus(0, -1, -1);

    $display("[TB] backpressure 1,0,0,1");
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    applyStimulus(1, -1, -1);

    $display("[TB] start while busy");
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    applyStimulus(0, 10, -1);

    $display("[TB] new dump from idle");
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    applyStimulus(0, -1, -1);

    $display("[TB] reset mid-scan");
    applyStimulus(0, -1, 13);
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    applyStimulus(0, -1, -1);

    $display("[TB] checksum pattern");
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1]  = 32'hFFFFFFFF;
    regs[15] = 32'h55AA55AA;
    applyStimulus(0, -1, -1);

    $display("[TB] random backpressure");
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      applyStimulus(2, -1, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug read-out engine for the RV32I register file: on a start pulse it walks the regfile read port across a register range and streams each value out over a valid/ready interface.
- Sits beside the core on one spare regfile read port (rs-side address out, data in); the read data path is combinational.
- Feeds a debug or UART bridge that may apply backpressure.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width
- FIRST_REG, 0, first register dumped
- LAST_REG, 31, last register dumped; legal range FIRST_REG <= LAST_REG <= 2**ADDR_W-1

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE
- o_busy  out  1  high whenever state != IDLE
- o_done  out  1  one-cycle pulse after the final beat handshakes
- o_rs_addr  out  ADDR_W  regfile read address, registered
- i_rs_data  in  DATA_W  regfile read data for o_rs_addr, same cycle
- o_dump_valid  out  1  output beat valid
- i_dump_ready  in  1  consumer accepts beat when valid & ready
- o_dump_data  out  DATA_W  beat payload
- o_dump_idx  out  ADDR_W  register index of beat
- o_dump_last  out  1  final beat of the dump

Behaviour:
- Reset, and any cycle with i_reset=1 including mid-scan: state=IDLE; o_busy, o_done, o_dump_valid and o_dump_last = 0; o_rs_addr, o_dump_data and o_dump_idx = 0; scan counter cleared. There is no partial-beat completion.
- States: IDLE, SCAN, DRAIN, plus CSUM with the optional feature.
- IDLE: if i_start=1, go to SCAN and set o_rs_addr=FIRST_REG. i_start while busy is ignored and is not queued.
- SCAN: the output register "loads" when o_dump_valid=0 or (o_dump_valid & i_dump_ready). On load:
  - o_dump_data=i_rs_data, o_dump_idx=o_rs_addr, o_dump_valid=1.
  - o_dump_last=1 if o_rs_addr==LAST_REG and the feature is off.
  - o_rs_addr increments.
  - If o_rs_addr==LAST_REG, go to DRAIN (or CSUM) and stop incrementing; no wrap past LAST_REG.
- If the output register is full and not accepted, o_dump_data, o_dump_idx, o_dump_last and o_rs_addr hold stable. Beats are never dropped or duplicated.
- Latency: start accepted at edge E0, first o_dump_valid=1 after E1.
- Throughput: with ready held high, LAST_REG-FIRST_REG+1 beats arrive in consecutive cycles.
- Each beat holds the regfile value at the cycle it was loaded. Concurrent regfile writes are visible only to registers not yet loaded.
- DRAIN: wait for the final handshake. Then o_dump_valid=0, o_dump_last=0, o_done=1 for one cycle, state=IDLE.
- o_dump_idx for x0 is 0 and its data is whatever the regfile returns; the block does not force zero.
- Single-register range (FIRST_REG==LAST_REG): one beat with last=1.

Optional Feature:
- Macro REGDUMP_CHECKSUM_EN.
- Defined: a running XOR of all dumped words is cleared on start and updated on each load. After the last register the block enters CSUM and emits one extra beat: data=XOR, idx=0, last=1. The register beat at LAST_REG has last=0. o_done follows the checksum handshake.
- Undefined: no CSUM state and no checksum logic; behaviour as described above.

Decomposition:
- Shared package riscv_pkg holds:
  - typedef regdump_state_e {IDLE, SCAN, DRAIN, CSUM}
  - REG_ADDR_W=5 and XLEN=32 constants, which are also used by regfile
- One natural sub-module, regdump_outreg: a single-entry valid/ready output register with load/hold logic, reusable by other stream sources.

Test Plan:
- Reset check: hold i_reset=1 for 2 cycles -> every output reads 0; o_busy=0.
- Full scan: preload reg5=DEADBEEF, reg10=12345678, reg31=CAFEBABE; pulse start with ready=1 -> 32 consecutive beats with idx 0..31 and matching data; last only on idx 31; o_done one cycle later.
- Backpressure: toggle i_dump_ready 1,0,0,1 repeating -> every beat delivered exactly once and in order; data and idx stable while valid & !ready.
- Start while busy: pulse i_start mid-scan -> no restart and exactly 32 beats; a start in IDLE after o_done -> a new dump.
- Reset mid-scan: assert i_reset after beat 12 -> valid=0 on the next cycle and IDLE; a fresh start then begins at idx 0.
- REGDUMP_CHECKSUM_EN: regs 0..31 preloaded with values, e.g. reg1=FFFFFFFF, reg15=55AA55AA, all others 0 -> 33 beats; the final beat has data=AA55AA55, idx=0, last=1.
